// File: rtl/uart_pkg.sv
// uart_pkg: shared state type and default constants for the UART blocks
package uart_pkg;
    localparam int DEF_CLKS_PER_BIT = 64;
    localparam int DEF_DATA_BITS = 8;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period timer with a one-cycle bit_end strobe
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic bit_end
);
    logic [15:0] cnt;
    assign bit_end = enable && cnt == 16'(CLKS_PER_BIT - 1);
    always_ff @(posedge clk) begin
        if (reset || restart || !enable || bit_end) cnt <= '0;
        else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: serial transmitter with optional even parity and 1 or 2 stop bits
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_done
);
    uart_tx_state_t state, state_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [3:0] bit_idx;
    logic stop_idx, par, bit_end, accept, tx_n;

    assign tx_ready = state == IDLE;
    assign accept = tx_ready && tx_valid;

    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk,
        .reset,
        .enable(state != IDLE),
        .restart(state_n != state),
        .bit_end
    );

    // tx is computed from the next state so the registered line lines up with the state
    always_comb begin
        state_n = state;
        if (accept) state_n = START;
        else if (bit_end)
            state_n = state == START ? DATA
                    : state == DATA ? (bit_idx == 4'(DATA_BITS - 1) ? (PARITY_EN != 0 ? PARITY : STOP) : DATA)
                    : state == PARITY ? STOP
                    : stop_idx == 1'(STOP_BITS - 1) ? IDLE : STOP;
        shreg_n = accept ? tx_data : (state == DATA && bit_end) ? shreg >> 1 : shreg;
        tx_n = state_n == START ? 1'b0
             : state_n == DATA ? shreg_n[0]
             : state_n == PARITY ? par
             : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            par      <= 1'b0;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            tx       <= tx_n;
            tx_done  <= state == STOP && state_n == IDLE;
            stop_idx <= state == STOP ? stop_idx ^ bit_end : 1'b0;
            if (accept) par <= ^tx_data;
            if (bit_end && state == DATA) bit_idx <= bit_idx == 4'(DATA_BITS - 1) ? '0 : bit_idx + 1'b1;
        end
    end
endmodule
